// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC and the instruction register, and runs
// a single outstanding request/ready handshake against instruction memory.
// A fetch ends in DONE (new instruction), or in the sticky ERR state on a
// misaligned PC or a memory that never answers. Only rst leaves ERR.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [6:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        fetch_err
);

  // TIMEOUT is limited to 1..255, so an 8-bit wait counter is enough.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_reg,      state_next;
  logic [31:0] pc_val_reg,     pc_val_next;
  logic [31:0] fetch_addr_reg, fetch_addr_next;
  logic [31:0] ir_reg,         ir_next;
  logic [7:0]  cnt_reg,        cnt_next;

  // State register; reset wins over every input, dropping any pending transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      pc_val_reg     <= RESET_PC;
      fetch_addr_reg <= RESET_PC;
      ir_reg         <= NOP_INSN;
      cnt_reg        <= 8'd0;
    end else begin
      state_reg      <= state_next;
      pc_val_reg     <= pc_val_next;
      fetch_addr_reg <= fetch_addr_next;
      ir_reg         <= ir_next;
      cnt_reg        <= cnt_next;
    end
  end

  // Next-state logic: handshake progress, wait-state timeout and PC updates.
  always_comb begin
    state_next      = state_reg;
    pc_val_next     = pc_val_reg;
    fetch_addr_next = fetch_addr_reg;
    ir_next         = ir_reg;
    cnt_next        = cnt_reg;

    case (state_reg)
      S_IDLE: begin
        // A simultaneous load still lets the fetch use the old PC.
        if (pc_load) begin
          pc_val_next = pc_next;
        end
        if (fetch_start) begin
          if (pc_val_reg[1:0] == 2'b00) begin
            fetch_addr_next = pc_val_reg;
            state_next      = S_REQ;
          end else begin
            state_next = S_ERR;
          end
        end
      end

      S_REQ: begin
        if (imem_ready) begin
          ir_next    = imem_rdata;
          state_next = S_DONE;
        end else begin
          cnt_next   = 8'd1;
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_ready) begin
          ir_next    = imem_rdata;
          state_next = S_DONE;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          state_next = S_ERR;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      S_DONE: begin
        // A new fetch_start here is ignored; the control unit re-requests from IDLE.
        if (pc_load) begin
          pc_val_next = pc_next;
        end
        state_next = S_IDLE;
      end

      S_ERR: begin
        state_next = S_ERR;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign imem_req   = (state_reg == S_REQ) || (state_reg == S_WAIT);
  assign imem_addr  = fetch_addr_reg;
  assign fetch_busy = imem_req;
  assign ir_valid   = (state_reg == S_DONE);
  assign fetch_err  = (state_reg == S_ERR);
  assign ir         = ir_reg;
  assign opcode     = ir_reg[6:0];
  assign pc         = pc_val_reg;
  assign pc_plus4   = pc_val_reg + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the fetch unit,
// with literal expectations pinning the model at the key points.
module tb_instr_fetch_unit;

  localparam int unsigned TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_start = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ir_valid;
  logic        fetch_busy;
  logic        fetch_err;

  int tests = 0;
  int fails = 0;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (TMO),
    .NOP_INSN (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_start(fetch_start),
    .pc_load    (pc_load),
    .pc_next    (pc_next),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .opcode     (opcode),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  // Model: a fetch is either in flight (busy), just delivered (done pulse),
  // failed for good (err), or nothing is happening.
  logic [31:0] m_pc, m_addr, m_ir;
  bit          m_busy, m_err, m_done, m_init;
  int          m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("imem_req",   32'(imem_req),   32'(m_busy));
    chk("fetch_busy", 32'(fetch_busy), 32'(m_busy));
    chk("imem_addr",  imem_addr,       m_addr);
    chk("ir",         ir,              m_ir);
    chk("opcode",     32'(opcode),     32'(m_ir[6:0]));
    chk("pc",         pc,              m_pc);
    chk("pc_plus4",   pc_plus4,        m_pc + 32'd4);
    chk("ir_valid",   32'(ir_valid),   32'(m_done));
    chk("fetch_err",  32'(fetch_err),  32'(m_err));
  endtask

  // One clock: work out what the unit must do with the current inputs,
  // take the edge, then check all outputs on the falling edge.
  task automatic step();
    logic [31:0] n_pc, n_addr, n_ir;
    bit n_busy, n_err, n_done;
    int n_stall;
    n_pc = m_pc; n_addr = m_addr; n_ir = m_ir;
    n_busy = m_busy; n_err = m_err; n_done = 1'b0; n_stall = m_stall;
    if (rst) begin
      n_pc = 32'h0; n_addr = 32'h0; n_ir = 32'h0000_0013;
      n_busy = 1'b0; n_err = 1'b0; n_stall = 0;
    end else if (m_err) begin
      // sticky until reset
    end else if (m_busy) begin
      if (imem_ready) begin
        n_ir = imem_rdata; n_busy = 1'b0; n_done = 1'b1;
      end else begin
        n_stall = m_stall + 1;
        if (n_stall > int'(TMO)) begin
          n_busy = 1'b0; n_err = 1'b1;
        end
      end
    end else begin
      if (pc_load) n_pc = pc_next;
      if (!m_done && fetch_start) begin
        if (m_pc % 4 != 0) begin
          n_err = 1'b1;
        end else begin
          n_busy = 1'b1; n_addr = m_pc; n_stall = 0;
        end
      end
    end
    @(posedge clk);
    if (rst) m_init = 1'b1;
    m_pc = n_pc; m_addr = n_addr; m_ir = n_ir;
    m_busy = n_busy; m_err = n_err; m_done = n_done; m_stall = n_stall;
    @(negedge clk);
    if (m_init) compare_model();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; fetch_start = 1'b0; pc_load = 1'b0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rnd;
    m_init = 1'b0;
    m_pc = '0; m_addr = '0; m_ir = '0;
    m_busy = 1'b0; m_err = 1'b0; m_done = 1'b0; m_stall = 0;

    // Reset state
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);

    // Zero-wait fetch
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("zw_req", 32'(imem_req), 32'h1);
    chk("zw_addr", imem_addr, 32'h0);
    imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    idle_inputs();
    chk("zw_valid", 32'(ir_valid), 32'h1);
    chk("zw_ir", ir, 32'h0050_0093);
    chk("zw_opcode", 32'(opcode), 32'h13);
    step();
    chk("zw_valid_pulse", 32'(ir_valid), 32'h0);

    // Three wait states
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ws_req", 32'(imem_req), 32'h1);
      chk("ws_busy", 32'(fetch_busy), 32'h1);
      chk("ws_addr", imem_addr, 32'h0);
      step();
    end
    imem_ready = 1'b1; imem_rdata = 32'h0000_2083;
    step();
    idle_inputs();
    chk("ws_valid", 32'(ir_valid), 32'h1);
    chk("ws_ir", ir, 32'h0000_2083);
    chk("ws_opcode", 32'(opcode), 32'h03);
    step();

    // Simultaneous pc_load and fetch_start; pc_load during WAIT ignored
    fetch_start = 1'b1; pc_load = 1'b1; pc_next = 32'h0000_0040;
    step();
    fetch_start = 1'b0; pc_load = 1'b0;
    chk("pu_addr", imem_addr, 32'h0);
    chk("pu_pc", pc, 32'h40);
    chk("pu_pc4", pc_plus4, 32'h44);
    step();
    pc_load = 1'b1; pc_next = 32'h0000_0080;
    step();
    chk("pu_wait_pc", pc, 32'h40);
    pc_load = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0010_0113;
    step();
    idle_inputs();
    step();

    // Timeout
    do_reset();
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < int'(TMO); i++) step();
    chk("to_not_yet", 32'(fetch_err), 32'h0);
    step();
    chk("to_err", 32'(fetch_err), 32'h1);
    chk("to_ir", ir, 32'h0000_0013);
    fetch_start = 1'b1; pc_load = 1'b1; pc_next = 32'h100; imem_ready = 1'b1;
    step(); step();
    idle_inputs();
    chk("to_req_off", 32'(imem_req), 32'h0);
    chk("to_sticky", 32'(fetch_err), 32'h1);
    chk("to_pc_held", pc, 32'h0);

    // Misaligned PC
    do_reset();
    pc_load = 1'b1; pc_next = 32'h0000_0102;
    step();
    pc_load = 1'b0; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("ma_err", 32'(fetch_err), 32'h1);
    chk("ma_req", 32'(imem_req), 32'h0);
    do_reset();
    chk("ma_rst_pc", pc, 32'h0);
    chk("ma_rst_err", 32'(fetch_err), 32'h0);

    // PC wrap, then reset in the middle of a WAIT
    pc_load = 1'b1; pc_next = 32'hFFFF_FFFC;
    step();
    pc_load = 1'b0;
    chk("wr_pc4", pc_plus4, 32'h0);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    chk("wr_in_wait", 32'(imem_req), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("wr_rst_req", 32'(imem_req), 32'h0);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("wr_late_valid", 32'(ir_valid), 32'h0);
    chk("wr_late_ir", ir, 32'h0000_0013);
    idle_inputs();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      fetch_start = $urandom_range(0, 1) == 1;
      pc_load     = ($urandom_range(0, 3) == 0);
      imem_ready  = ($urandom_range(0, 9) < 3);
      imem_rdata  = $urandom;
      rnd = $urandom;
      case ($urandom_range(0, 15))
        0:       pc_next = rnd;
        1:       pc_next = 32'hFFFF_FFFC;
        default: pc_next = {rnd[31:2], 2'b00};
      endcase
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
